clk_switch_ctrl: RTL
====================

CLK_SWITCH_CTRL -- requirements
Module: clk_switch_ctrl

Interface
REQ-001 Parameter MON_WINDOW, default 64: clk cycles over which target-clock activity is measured; legal range 8..1023.
REQ-002 Parameter MIN_EDGES, default 4: minimum synchronized rising edges in the window for the target to count as alive.
REQ-003 Parameter SETTLE_CYCLES, default 8: clk cycles held after a sel change before done; legal range 1..255.
REQ-004 Port: clk  input  1  controller clock; one clock domain; all state is updated on the rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: req  input  1  switch request; sampled only in IDLE.
REQ-007 Port: req_src  input  1  requested source; 0 = clk_1, 1 = clk_2; sampled with req.
REQ-008 Port: clk_1_mon, clk_2_mon  input  1 each  raw copies of clk_1 and clk_2; asynchronous to clk.
REQ-009 Port: sel  output  1  registered select to the glitch-free clock mux.
REQ-010 Port: cur_src  output  1  currently committed source.
REQ-011 Port: busy  output  1  high in every state except IDLE.
REQ-012 Port: done, err  output  1 each  single-cycle completion and failure pulses.

Function
REQ-013 FSM states: IDLE, CHECK, SWITCH, SETTLE, DONE, ERR.
REQ-014 IDLE, req=1, req_src≠cur_src: go to CHECK; latch req_src.
REQ-015 IDLE, req=1, req_src==cur_src: go to DONE; sel is unchanged and no check runs.
REQ-016 req is ignored while busy=1; the controller does not queue requests.
REQ-017 Each mon input passes through a 2-flop synchronizer, then rising-edge detect on the synchronized signal.
REQ-018 CHECK:
- runs exactly MON_WINDOW cycles;
- counts edges of the target monitor only;
- the edge counter saturates at MIN_EDGES.
REQ-019 End of CHECK: count ≥ MIN_EDGES → SWITCH; otherwise → ERR.
REQ-020 SWITCH lasts one cycle; sel ← latched source, registered.
REQ-021 SETTLE counts SETTLE_CYCLES cycles, then goes to DONE.
REQ-022 DONE lasts one cycle: done=1, cur_src ← sel, then IDLE.
REQ-023 ERR lasts one cycle: err=1; sel and cur_src are unchanged; then IDLE.
REQ-024 Cycle timing for req sampled at edge N with a source change:
- sel changes at edge N+MON_WINDOW+1;
- done is high during the cycle after edge N+MON_WINDOW+SETTLE_CYCLES+2.
REQ-025 Cycle timing for the same-source case: done is high in the cycle after edge N+1.
REQ-026 done and err are never high together; each is high for exactly one cycle per accepted request.
REQ-027 sel changes only on the SWITCH transition; it never toggles twice within one request.
REQ-028 The monitored clocks must be slower than clk/2; faster clocks are outside the contract and may cause edges to be missed.

Reset
REQ-029 reset=1 at a clock edge forces:
- state = IDLE;
- sel = 0, cur_src = 0;
- busy = 0, done = 0, err = 0;
- all counters and synchronizer flops = 0.
REQ-030 Reset asserted mid-operation, in any state, aborts the request; no done or err pulse is emitted for it.
REQ-031 The first request may be accepted in the cycle after reset deasserts.

Structure
REQ-032 A shared package clk_switch_pkg holds:
- the state enum;
- the counter width constants, derived with $clog2 from the parameters.
REQ-033 Sub-module clk_activity_mon is instantiated twice, once per source. It contains:
- the 2-flop synchronizer;
- the rising-edge detector;
- a saturating edge counter with a clear input.
REQ-034 The top level holds the FSM, the window counter, the settle counter and the output registers only.

Verification
REQ-035 Reset, then req=1 with req_src=1, clk_2_mon at clk/10 → sel=1 at edge 65, done pulse after edge 74, cur_src=1.
REQ-036 Reset, then req=1 with req_src=1, clk_2_mon stuck at 0 → err pulse after edge 65; sel=0 and cur_src=0 throughout.
REQ-037 cur_src=0, req=1 with req_src=0 → done after one cycle; busy high for one cycle; sel stays 0.
REQ-038 req pulsed again during CHECK with the opposite source → ignored; exactly one done pulse.
REQ-039 reset asserted during SETTLE → next cycle sel=0, cur_src=0, busy=0; no done pulse.
REQ-040 clk_2_mon gives 3 edges in the window, MIN_EDGES=4 → err; at exactly 4 edges → switch succeeds.

Source files
------------

// File: rtl/clk_switch_pkg.sv
// rtl/clk_switch_pkg.sv - shared state encoding and counter widths for the clock switch controller
package clk_switch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SWITCH,
        ST_SETTLE,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int MON_WINDOW_MAX    = 1023;
    localparam int SETTLE_CYCLES_MAX = 255;
    localparam int WIN_W             = $clog2(MON_WINDOW_MAX + 1);
    localparam int SETTLE_W          = $clog2(SETTLE_CYCLES_MAX + 1);

    function automatic int edge_cnt_w(input int min_edges);
        return $clog2(min_edges + 1);
    endfunction

endpackage

// File: rtl/clk_activity_mon.sv
// rtl/clk_activity_mon.sv - synchronizes one raw clock copy and counts its rising edges up to a saturation limit
module clk_activity_mon
    import clk_switch_pkg::*;
#(
    parameter int MIN_EDGES = 4,
    localparam int CW = edge_cnt_w(MIN_EDGES)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_mon,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_alive
);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_prev;
    logic [CW-1:0] r_cnt;
    logic          w_rise;

    assign w_rise = r_sync2 & ~r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_mon;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (i_clear)
                r_cnt <= '0;
            else if (i_count_en && w_rise && (r_cnt < CW'(MIN_EDGES)))
                r_cnt <= r_cnt + CW'(1);
        end
    end

    // An edge in the final window cycle still counts toward the verdict.
    assign o_alive = (r_cnt == CW'(MIN_EDGES)) ||
                     (i_count_en && w_rise && (r_cnt == CW'(MIN_EDGES - 1)));

endmodule

// File: rtl/clk_switch_ctrl.sv
// rtl/clk_switch_ctrl.sv - verifies target clock activity, then drives a glitch-free mux select
module clk_switch_ctrl
    import clk_switch_pkg::*;
#(
    parameter int MON_WINDOW    = 64,
    parameter int MIN_EDGES     = 4,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic req_src,
    input  logic clk_1_mon,
    input  logic clk_2_mon,
    output logic sel,
    output logic cur_src,
    output logic busy,
    output logic done,
    output logic err
);

    state_t              r_state;
    state_t              w_next;
    logic [WIN_W-1:0]    r_win;
    logic [SETTLE_W-1:0] r_settle;
    logic                r_target;
    logic                r_sel;
    logic                r_cur;
    logic                r_done;
    logic                r_err;
    logic                w_check;
    logic                w_alive_1;
    logic                w_alive_2;
    logic                w_alive;

    assign w_check = (r_state == ST_CHECK);
    assign w_alive = r_target ? w_alive_2 : w_alive_1;

    clk_activity_mon #(.MIN_EDGES(MIN_EDGES)) u_mon_1 (
        .clk        (clk),
        .reset      (reset),
        .i_mon      (clk_1_mon),
        .i_clear    (~w_check),
        .i_count_en (w_check & ~r_target),
        .o_alive    (w_alive_1)
    );

    clk_activity_mon #(.MIN_EDGES(MIN_EDGES)) u_mon_2 (
        .clk        (clk),
        .reset      (reset),
        .i_mon      (clk_2_mon),
        .i_clear    (~w_check),
        .i_count_en (w_check & r_target),
        .o_alive    (w_alive_2)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (req) w_next = (req_src != r_cur) ? ST_CHECK : ST_DONE;
            ST_CHECK:  if (r_win == WIN_W'(MON_WINDOW - 1)) w_next = w_alive ? ST_SWITCH : ST_ERR;
            ST_SWITCH: w_next = ST_SETTLE;
            ST_SETTLE: if (r_settle == SETTLE_W'(SETTLE_CYCLES - 1)) w_next = ST_DONE;
            ST_DONE:   w_next = ST_IDLE;
            ST_ERR:    w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_win    <= '0;
            r_settle <= '0;
            r_target <= 1'b0;
            r_sel    <= 1'b0;
            r_cur    <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_win    <= w_check ? r_win + WIN_W'(1) : '0;
            r_settle <= (r_state == ST_SETTLE) ? r_settle + SETTLE_W'(1) : '0;
            // Pulses are registered off the state, so they trail DONE/ERR by one cycle.
            r_done   <= (r_state == ST_DONE);
            r_err    <= (r_state == ST_ERR);
            if (r_state == ST_IDLE && req)
                r_target <= req_src;
            if (r_state == ST_SWITCH)
                r_sel <= r_target;
            if (r_state == ST_DONE)
                r_cur <= r_sel;
        end
    end

    assign sel     = r_sel;
    assign cur_src = r_cur;
    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;
    assign err     = r_err;

endmodule
